mux_arbiter: RTL and testbench

Round-robin arbiter and output sequencer for the 2:1 data mux path. Two requesters present `DATA_WIDTH`-bit words with a valid/ready handshake. The block grants one requester at a time and registers the accepted word into a single output stage. It drives `selector` so the mux select and the downstream consumer always see the source of the word currently held.

---
 rtl/mux_arbiter_if.sv | 25 ++
 rtl/mux_arbiter.sv | 121 ++++++++++++
 tb/tb_mux_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mux_arbiter_if.sv
// Handshake bundle between two requesters, the mux arbiter and the downstream consumer.
interface mux_arbiter_if #(
  parameter int DATA_WIDTH = 2
);
  logic                  valid0;
  logic [DATA_WIDTH-1:0] data_in0;
  logic                  ready0;
  logic                  valid1;
  logic [DATA_WIDTH-1:0] data_in1;
  logic                  ready1;
  logic                  out_ready;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  selector;

  modport master (
    output valid0, data_in0, valid1, data_in1, out_ready,
    input  ready0, ready1, valid_out, data_out, selector
  );

  modport slave (
    input  valid0, data_in0, valid1, data_in1, out_ready,
    output ready0, ready1, valid_out, data_out, selector
  );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin 2:1 arbiter with a single registered output stage and source selector.
// Optional MUX_ARB_BURST_EN: release a grant after MAX_BURST consecutive transfers.
module mux_arbiter #(
  parameter int DATA_WIDTH = 2,
  parameter int MAX_BURST  = 4
) (
  input  logic         clk,
  input  logic         reset,
  mux_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_burst_range
    $error("MAX_BURST must be in 1..16");
  end

  state_t                state, state_nxt;
  logic                  last_grant, last_grant_nxt;
  logic [3:0]            burst_cnt, burst_cnt_nxt;
  logic                  load_ok;
  logic                  xfer0, xfer1, xfer;
  logic                  cur_valid, other_valid;
  logic                  burst_done, rel_grant;
  logic                  valid_out_p0, selector_p0;
  logic [DATA_WIDTH-1:0] data_out_p0;
  logic [DATA_WIDTH-1:0] word_nxt;

  assign load_ok     = !valid_out_p0 || bus.out_ready;
  assign bus.ready0  = (state == GRANT0) && load_ok;
  assign bus.ready1  = (state == GRANT1) && load_ok;
  assign xfer0       = bus.valid0 && bus.ready0;
  assign xfer1       = bus.valid1 && bus.ready1;
  assign xfer        = xfer0 || xfer1;
  assign cur_valid   = (state == GRANT1) ? bus.valid1 : bus.valid0;
  assign other_valid = (state == GRANT1) ? bus.valid0 : bus.valid1;

`ifdef MUX_ARB_BURST_EN
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
  assign burst_done = xfer && (burst_cnt == BURST_LAST);
`else
  assign burst_done = 1'b0;
`endif

  // A stall under backpressure keeps valid high, so the grant is held.
  assign rel_grant = burst_done || !cur_valid;

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    case (state)
      IDLE: begin
        if (bus.valid0 && bus.valid1) begin
          state_nxt      = last_grant ? GRANT0 : GRANT1;
          last_grant_nxt = !last_grant;
          burst_cnt_nxt  = 4'd0;
        end else if (bus.valid0) begin
          state_nxt      = GRANT0;
          last_grant_nxt = 1'b0;
          burst_cnt_nxt  = 4'd0;
        end else if (bus.valid1) begin
          state_nxt      = GRANT1;
          last_grant_nxt = 1'b1;
          burst_cnt_nxt  = 4'd0;
        end
      end
      GRANT0, GRANT1: begin
        if (xfer) begin
          burst_cnt_nxt = burst_cnt + 4'd1;
        end
        if (rel_grant) begin
          if (other_valid) begin
            state_nxt      = (state == GRANT0) ? GRANT1 : GRANT0;
            last_grant_nxt = (state == GRANT0);
            burst_cnt_nxt  = 4'd0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      burst_cnt  <= 4'd0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  assign word_nxt = xfer1 ? bus.data_in1 : bus.data_in0;

  // Stage p0: output register; holds its word until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out_p0 <= 1'b0;
      data_out_p0  <= '0;
      selector_p0  <= 1'b0;
    end else if (xfer) begin
      valid_out_p0 <= 1'b1;
      data_out_p0  <= word_nxt;
      selector_p0  <= xfer1;
    end else if (bus.out_ready) begin
      valid_out_p0 <= 1'b0;
    end
  end

  assign bus.valid_out = valid_out_p0;
  assign bus.data_out  = data_out_p0;
  assign bus.selector  = selector_p0;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter with MAX_BURST=2; expectations follow MUX_ARB_BURST_EN.
module tb_mux_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mux_arbiter_if #(.DATA_WIDTH(2)) bus ();

  mux_arbiter #(.DATA_WIDTH(2), .MAX_BURST(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] d, input logic s);
    chk({tag, "_valid"}, 32'(bus.valid_out), 32'(v));
    chk({tag, "_data"},  32'(bus.data_out),  32'(d));
    chk({tag, "_sel"},   32'(bus.selector),  32'(s));
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.valid0    = 1'b0;
    bus.valid1    = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] fair_d [6];
    logic       fair_s [6];
    fair_d = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1};
    fair_s = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset held two cycles with both requesters active
    bus.valid0    = 1'b1;
    bus.valid1    = 1'b1;
    bus.data_in0  = 2'd1;
    bus.data_in1  = 2'd2;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out("rst", 1'b0, 2'd0, 1'b0);
      chk("rst_ready0", 32'(bus.ready0), 32'd0);
      chk("rst_ready1", 32'(bus.ready1), 32'd0);
    end
    reset = 1'b0;
    settle();
    chk("idle_ready0", 32'(bus.ready0), 32'd0);
    tick();
    chk("first_grant_ready0", 32'(bus.ready0), 32'd1);
    chk("first_grant_ready1", 32'(bus.ready1), 32'd0);

    // Single requester streaming 0..3
    do_reset();
    bus.valid0   = 1'b1;
    bus.data_in0 = 2'd0;
    settle();
    chk("single_ready_lat0", 32'(bus.ready0), 32'd0);
    tick();
    chk("single_ready_lat1", 32'(bus.ready0), 32'd1);
    for (int w = 0; w < 4; w++) begin
      bus.data_in0 = 2'(w);
`ifdef MUX_ARB_BURST_EN
      if (w == 2) begin
        tick();
        chk("single_bubble_valid", 32'(bus.valid_out), 32'd0);
        chk("single_bubble_data", 32'(bus.data_out), 32'd1);
      end
`endif
      tick();
      chk_out("single", 1'b1, 2'(w), 1'b0);
    end
    bus.valid0 = 1'b0;

`ifdef MUX_ARB_BURST_EN
    // Fair sharing between two always-valid requesters
    do_reset();
    bus.valid0   = 1'b1;
    bus.valid1   = 1'b1;
    bus.data_in0 = 2'd1;
    bus.data_in1 = 2'd2;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out("fair", 1'b1, fair_d[i], fair_s[i]);
    end
`else
    // Without burst limit, requester 0 keeps the grant while valid
    do_reset();
    bus.valid0   = 1'b1;
    bus.valid1   = 1'b1;
    bus.data_in0 = 2'd0;
    bus.data_in1 = 2'd2;
    tick();
    for (int k = 0; k < 8; k++) begin
      bus.data_in0 = 2'(k);
      tick();
      chk_out("hold", 1'b1, 2'(k), 1'b0);
    end
    bus.valid0 = 1'b0;
    tick();
    chk("switch_ready1", 32'(bus.ready1), 32'd1);
    chk("switch_ready0", 32'(bus.ready0), 32'd0);
    tick();
    chk_out("switch", 1'b1, 2'd2, 1'b1);
    bus.valid1 = 1'b0;
`endif

    // Backpressure during a GRANT0 burst
    do_reset();
    bus.valid0   = 1'b1;
    bus.data_in0 = 2'd1;
    tick();
    tick();
    chk_out("bp_first", 1'b1, 2'd1, 1'b0);
    bus.out_ready = 1'b0;
    bus.data_in0  = 2'd2;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_ready0", 32'(bus.ready0), 32'd0);
      tick();
      chk_out("bp_hold", 1'b1, 2'd1, 1'b0);
      chk("bp_cnt", 32'(dut.burst_cnt), 32'd1);
    end
    bus.out_ready = 1'b1;
    settle();
    chk("bp_resume_ready0", 32'(bus.ready0), 32'd1);
    tick();
    chk_out("bp_resume", 1'b1, 2'd2, 1'b0);
    bus.data_in0 = 2'd3;
`ifdef MUX_ARB_BURST_EN
    tick();
    chk("bp_release_valid", 32'(bus.valid_out), 32'd0);
    chk("bp_release_data", 32'(bus.data_out), 32'd2);
`endif
    tick();
    chk_out("bp_next", 1'b1, 2'd3, 1'b0);
    bus.valid0 = 1'b0;

    // Reset while GRANT1 holds an output word
    do_reset();
    bus.valid1   = 1'b1;
    bus.data_in1 = 2'd3;
    tick();
    tick();
    chk_out("midrst_before", 1'b1, 2'd3, 1'b1);
    reset      = 1'b1;
    bus.valid0 = 1'b1;
    tick();
    chk_out("midrst", 1'b0, 2'd0, 1'b0);
    chk("midrst_ready1", 32'(bus.ready1), 32'd0);
    reset = 1'b0;
    settle();
    chk("midrst_idle_ready0", 32'(bus.ready0), 32'd0);
    tick();
    chk("midrst_grant_ready0", 32'(bus.ready0), 32'd1);
    chk("midrst_grant_ready1", 32'(bus.ready1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
